vend_dispense_ctrl: RTL and testbench

Dispense sequencer behind the vending core. Takes each completed sale (soda pulse plus change count in nickels), queues it, and drives the physical actuators: soda motor for a fixed time, then one timed eject pulse per returned nickel. Asserts a coin-inhibit while the queue is full, so the coin mechanism rejects new coins instead of the controller losing a sale.

---
 rtl/vend_pkg.sv | 15 +
 rtl/vend_fifo.sv | 49 ++++
 rtl/vend_dispense_ctrl.sv | 148 ++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense path.
// Imported by the dispense sequencer and its pending-vend queue.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MOTOR = 2'd1,
      EJECT = 2'd2,
      GAP   = 2'd3
   } dispense_state_t;

   localparam logic [2:0] MAX_CHANGE    = 3'd4;
   localparam int         PRICE_NICKELS = 4;

endpackage

// File: rtl/vend_fifo.sv
// Synchronous FIFO with fall-through head, count/full/empty status.
// A push on a full queue is taken only when a pop happens in the same cycle.
module vend_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: queues completed sales, runs the soda motor, then
// ejects one timed pulse per nickel of change.
import vend_pkg::*;

module vend_dispense_ctrl #(
   parameter int MOTOR_CYCLES = 4,
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 2,
   parameter int DEPTH        = 2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       vend_valid_i,
   input  logic [2:0] change_i,
   output logic       soda_motor_o,
   output logic       nickel_eject_o,
   output logic       coin_inhibit_o,
   output logic       busy_o,
   output logic       vend_done_o,
   output logic       err_o
);

   localparam int MAX_MP  = (MOTOR_CYCLES > PULSE_CYCLES) ? MOTOR_CYCLES : PULSE_CYCLES;
   localparam int MAX_ALL = (MAX_MP > GAP_CYCLES) ? MAX_MP : GAP_CYCLES;
   localparam int CW      = $clog2(MAX_ALL + 1);
   localparam int QW      = $clog2(DEPTH) + 1;

   // vend_valid_i has no ready: coin_inhibit_o is the only backpressure, and a
   // vend arriving while the queue is full (with no pop that cycle) is dropped.
   dispense_state_t state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      cur_change, chg_n, chg_dec;
   logic            pop;
   logic [2:0]      change_clamped;
   logic            illegal, overflow, push_ok;
   logic [2:0]      q_head;
   logic            q_full, q_empty;
   logic [QW-1:0]   q_count, count_nxt;
   logic            err_evt_q;

   assign illegal        = vend_valid_i & (change_i > MAX_CHANGE);
   assign change_clamped = (change_i > MAX_CHANGE) ? MAX_CHANGE : change_i;
   assign push_ok        = vend_valid_i & (~q_full | pop);
   assign overflow       = vend_valid_i & q_full & ~pop;
   assign count_nxt      = q_count + {{(QW-1){1'b0}}, push_ok} - {{(QW-1){1'b0}}, pop};
   assign chg_dec        = cur_change - 3'd1;

   vend_fifo #(.WIDTH(3), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push    (vend_valid_i),
      .pop     (pop),
      .wdata   (change_clamped),
      .rdata   (q_head),
      .full    (q_full),
      .empty   (q_empty),
      .count   (q_count)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state      <= IDLE;
         cnt        <= '0;
         cur_change <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         cur_change <= chg_n;
      end
   end

   // Timers load the full cycle count and expire when they reach 1.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      chg_n   = cur_change;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!q_empty) begin
               pop     = 1'b1;
               chg_n   = q_head;
               cnt_n   = CW'(MOTOR_CYCLES);
               state_n = MOTOR;
            end
         end
         MOTOR: begin
            if (cnt == CW'(1)) begin
               if (cur_change == 3'd0) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else begin
                  state_n = EJECT;
                  cnt_n   = CW'(PULSE_CYCLES);
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         EJECT: begin
            if (cnt == CW'(1)) begin
               chg_n = chg_dec;
               if (chg_dec == 3'd0) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else begin
                  state_n = GAP;
                  cnt_n   = CW'(GAP_CYCLES);
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         GAP: begin
            if (cnt == CW'(1)) begin
               state_n = EJECT;
               cnt_n   = CW'(PULSE_CYCLES);
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Actuator outputs track the state register; inhibit and error report
   // the queue/error condition of the previous cycle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         err_evt_q      <= 1'b0;
         soda_motor_o   <= 1'b0;
         nickel_eject_o <= 1'b0;
         coin_inhibit_o <= 1'b0;
         busy_o         <= 1'b0;
         vend_done_o    <= 1'b0;
         err_o          <= 1'b0;
      end else begin
         err_evt_q      <= err_evt_q | illegal | overflow;
         soda_motor_o   <= (state_n == MOTOR);
         nickel_eject_o <= (state_n == EJECT);
         coin_inhibit_o <= q_full;
         busy_o         <= (state_n != IDLE) | (count_nxt != '0);
         vend_done_o    <= ((state == MOTOR) | (state == EJECT)) & (state_n == IDLE);
         err_o          <= err_evt_q;
      end
   end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl with a per-vend scoreboard of
// expected nickel counts checked on every vend_done_o.
module tb_vend_dispense_ctrl;

   logic       clk_i;
   logic       reset_i;
   logic       vend_valid_i;
   logic [2:0] change_i;
   logic       soda_motor_o;
   logic       nickel_eject_o;
   logic       coin_inhibit_o;
   logic       busy_o;
   logic       vend_done_o;
   logic       err_o;

   int errors = 0;
   int checks = 0;
   logic [2:0] exp_q[$];
   int motor_runs = 0;
   int done_total = 0;

   vend_dispense_ctrl #(
      .MOTOR_CYCLES(4), .PULSE_CYCLES(2), .GAP_CYCLES(2), .DEPTH(2)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .vend_valid_i   (vend_valid_i),
      .change_i       (change_i),
      .soda_motor_o   (soda_motor_o),
      .nickel_eject_o (nickel_eject_o),
      .coin_inhibit_o (coin_inhibit_o),
      .busy_o         (busy_o),
      .vend_done_o    (vend_done_o),
      .err_o          (err_o)
   );

   // clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // driver: called at a negedge; vend sampled at the next posedge (edge k),
   // returns at the negedge inside cycle k
   task automatic pulse_vend(input logic [2:0] ch, input bit accept);
      vend_valid_i = 1'b1;
      change_i     = ch;
      if (accept) exp_q.push_back((ch > 3'd4) ? 3'd4 : ch);
      @(posedge clk_i);
      @(negedge clk_i);
      vend_valid_i = 1'b0;
      change_i     = 3'd0;
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (!busy_o) begin
            done = 1'b1;
            break;
         end
      end
      chk(tag, 8'(done), 8'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_motor"}, 8'(soda_motor_o), 8'd0);
      chk({tag, "_eject"}, 8'(nickel_eject_o), 8'd0);
      chk({tag, "_inhibit"}, 8'(coin_inhibit_o), 8'd0);
      chk({tag, "_busy"}, 8'(busy_o), 8'd0);
      chk({tag, "_done"}, 8'(vend_done_o), 8'd0);
      chk({tag, "_err"}, 8'(err_o), 8'd0);
   endtask

   // cycle-exact trace of one vend into an idle, empty controller
   task automatic trace_vend(input logic [2:0] ch);
      int n, last, off;
      logic em, ee;
      n    = int'(ch);
      last = (n == 0) ? 5 : 4 * n + 3;
      pulse_vend(ch, 1'b1);
      for (int t = 0; t <= last + 1; t++) begin
         if (t > 0) @(negedge clk_i);
         em = (t >= 1 && t <= 4);
         ee = 1'b0;
         if (t >= 5) begin
            off = t - 5;
            ee  = ((off / 4) < n) && ((off % 4) < 2);
         end
         chk($sformatf("trace%0d_motor_t%0d", n, t), 8'(soda_motor_o), 8'(em));
         chk($sformatf("trace%0d_eject_t%0d", n, t), 8'(nickel_eject_o), 8'(ee));
         chk($sformatf("trace%0d_done_t%0d", n, t), 8'(vend_done_o), 8'(t == last));
         chk($sformatf("trace%0d_busy_t%0d", n, t), 8'(busy_o), 8'(t < last));
      end
   endtask

   // scoreboard monitor, samples 1 time unit after each active edge
   int  mot_len = 0, nick = 0, pulse_len = 0;
   logic prev_eject = 1'b0, prev_soda = 1'b0;
   logic [2:0] exp_n;

   always @(posedge clk_i) begin
      #1;
      if (reset_i) begin
         mot_len = 0; nick = 0; pulse_len = 0;
         prev_eject = 1'b0; prev_soda = 1'b0;
      end else begin
         if (soda_motor_o) mot_len++;
         if (soda_motor_o && !prev_soda) motor_runs++;
         if (nickel_eject_o) begin
            if (!prev_eject) nick++;
            pulse_len++;
         end else if (prev_eject) begin
            chk("pulse_width", 8'(pulse_len), 8'd2);
            pulse_len = 0;
         end
         if (vend_done_o) begin
            done_total++;
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("FAIL sb_unexpected_done: observed=done expected=no_done");
            end
            if (exp_q.size() > 0) begin
               exp_n = exp_q.pop_front();
               chk("sb_nickels", 8'(nick), 8'(exp_n));
               chk("sb_motor_len", 8'(mot_len), 8'd4);
            end
            mot_len = 0; nick = 0;
         end
         prev_eject = nickel_eject_o;
         prev_soda  = soda_motor_o;
      end
   end

   initial begin
      int  dones, t, t_done, t_rise;
      bit  finished, seen, bad;

      reset_i      = 1'b1;
      vend_valid_i = 1'b0;
      change_i     = 3'd0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk_all_zero("reset");
      reset_i = 1'b0;
      @(negedge clk_i);

      // single vends, cycle-exact
      trace_vend(3'd0);
      trace_vend(3'd3);
      wait_idle("idle_after_traces");

      // back-to-back: change 1 at k, change 4 at k+2
      pulse_vend(3'd1, 1'b1);
      @(negedge clk_i);
      pulse_vend(3'd4, 1'b1);
      dones = 0; t = 2; t_done = -1; t_rise = -1; finished = 1'b0;
      prev_soda_b: for (int i = 0; i < 80; i++) begin
         @(negedge clk_i);
         t++;
         if (vend_done_o) begin
            dones++;
            if (t_done < 0) t_done = t;
         end
         if (soda_motor_o && t_done >= 0 && t_rise < 0) t_rise = t;
         if (!busy_o && dones == 2) begin
            finished = 1'b1;
            break;
         end
      end
      chk("b2b_finished", 8'(finished), 8'd1);
      chk("b2b_done_count", 8'(dones), 8'd2);
      chk("b2b_one_idle_gap", 8'(t_rise - t_done), 8'd1);
      chk("b2b_no_err", 8'(err_o), 8'd0);

      // overflow: vends at k, k+2, k+3, k+4 (last one dropped)
      motor_runs = 0;
      pulse_vend(3'd0, 1'b1);
      @(negedge clk_i);
      pulse_vend(3'd1, 1'b1);
      pulse_vend(3'd2, 1'b1);
      chk("ovf_inhibit_k3", 8'(coin_inhibit_o), 8'd0);
      pulse_vend(3'd3, 1'b0);
      chk("ovf_inhibit_k4", 8'(coin_inhibit_o), 8'd1);
      chk("ovf_err_k4", 8'(err_o), 8'd0);
      @(negedge clk_i);
      chk("ovf_err_k5", 8'(err_o), 8'd1);
      wait_idle("ovf_drain");
      chk("ovf_motor_runs", 8'(motor_runs), 8'd3);
      chk("ovf_err_sticky", 8'(err_o), 8'd1);
      chk("ovf_inhibit_clear", 8'(coin_inhibit_o), 8'd0);

      // reset held 2 cycles during EJECT
      pulse_vend(3'd3, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_i);
         if (nickel_eject_o) begin
            seen = 1'b1;
            break;
         end
      end
      chk("rst_reached_eject", 8'(seen), 8'd1);
      reset_i = 1'b1;
      exp_q.delete();
      @(posedge clk_i);
      @(negedge clk_i);
      chk_all_zero("rst_mid");
      @(negedge clk_i);
      reset_i = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (soda_motor_o || nickel_eject_o || busy_o || vend_done_o || err_o) bad = 1'b1;
      end
      chk("rst_quiet_after", 8'(bad), 8'd0);

      // illegal change clamps to 4 nickels and sets sticky err
      pulse_vend(3'd6, 1'b1);
      wait_idle("clamp_drain");
      chk("clamp_err", 8'(err_o), 8'd1);
      pulse_vend(3'd0, 1'b1);
      wait_idle("clamp_drain2");
      chk("clamp_err_sticky", 8'(err_o), 8'd1);
      reset_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      chk("clamp_err_cleared", 8'(err_o), 8'd0);

      @(negedge clk_i);
      chk("sb_queue_empty", 8'(exp_q.size()), 8'd0);
      chk("done_total", 8'(done_total), 8'd9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
